// File: rtl/spike_sched_pkg.sv
// spike_sched_pkg: shared state encoding and default widths for the spike
// dispatch scheduler.
//
// Configuration buses are packed MSB-first: element 0 occupies the most
// significant field, so element k of an N-entry bus of W-bit fields lives at
// bits [(N-1-k)*W +: W].
package spike_sched_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_PTR_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_INTEGRATE,
        ST_SCAN,
        ST_DISPATCH
    } sched_state_t;

endpackage

// File: rtl/spike_priority_enc.sv
// spike_priority_enc: combinational lowest-set-bit encoder used to pick the
// next pending neuron to dispatch.
module spike_priority_enc
    import spike_sched_pkg::*;
#(
    parameter int N     = 10,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk from the top down so the lowest set bit is the last assignment.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_dispatch_scheduler.sv
// spike_dispatch_scheduler: timestep controller and CSR-driven spike
// dispatcher for one neuron tile. Emits the per-timestep clear pulse,
// collects spikes while integrating, then walks each spiking neuron's
// downstream list issuing one {dest, source} delivery per handshake.
// Optional build macro: SCHED_STALL_COUNT_EN adds the stall_cycles output.
module spike_dispatch_scheduler
    import spike_sched_pkg::*;
#(
    parameter int NUM_NEURONS     = 10,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int PTR_W           = DEF_PTR_W,
    parameter int MAX_CONN        = 30,
    parameter int TIMESTEP_CYCLES = 4
) (
    input  logic                             CLK,
    input  logic                             RESETn,
    input  logic                             start,
    input  logic                             cfg_load,
    input  logic [NUM_NEURONS*ADDR_W-1:0]    neuron_addresses_initialization,
    input  logic [(NUM_NEURONS+1)*PTR_W-1:0] connection_pointer_initialization,
    input  logic [MAX_CONN*ADDR_W-1:0]       downstream_connections_initialization,
    input  logic [NUM_NEURONS-1:0]           spikes,
    output logic                             clear,
    output logic [15:0]                      timestep,
    output logic                             dlv_valid,
    input  logic                             dlv_ready,
    output logic [ADDR_W-1:0]                dlv_dest,
    output logic [ADDR_W-1:0]                dlv_source,
    output logic                             busy,
    output logic                             cfg_err
`ifdef SCHED_STALL_COUNT_EN
    ,
    output logic [15:0]                      stall_cycles
`endif
);

    localparam int IDX_W = $clog2(NUM_NEURONS + 1);
    localparam int CNT_W = $clog2(TIMESTEP_CYCLES + 1);

    sched_state_t                     state, state_next;
    logic [NUM_NEURONS*ADDR_W-1:0]    naddr_cfg;
    logic [(NUM_NEURONS+1)*PTR_W-1:0] cp_cfg;
    logic [MAX_CONN*ADDR_W-1:0]       ds_cfg;
    logic [NUM_NEURONS-1:0]           pending;
    logic [CNT_W-1:0]                 cnt;
    logic [PTR_W-1:0]                 ptr, end_ptr, ptr_inc;
    logic [PTR_W-1:0]                 scan_ptr, scan_end;
    logic [IDX_W-1:0]                 sel_idx;
    logic                             sel_any, scan_bad, scan_empty, dispatch_last;

    // Field extractors return 0 for out-of-range indices so that nothing
    // ever reads past the end of a configuration bus.
    function automatic logic [ADDR_W-1:0] naddr_at(input logic [IDX_W-1:0] i);
        naddr_at = '0;
        if (int'(i) < NUM_NEURONS)
            naddr_at = naddr_cfg[(NUM_NEURONS - 1 - int'(i)) * ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [PTR_W-1:0] cp_at(input logic [IDX_W-1:0] i);
        cp_at = '0;
        if (int'(i) <= NUM_NEURONS)
            cp_at = cp_cfg[(NUM_NEURONS - int'(i)) * PTR_W +: PTR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] ds_at(input logic [PTR_W-1:0] p);
        ds_at = '0;
        if (int'(p) < MAX_CONN)
            ds_at = ds_cfg[(MAX_CONN - 1 - int'(p)) * ADDR_W +: ADDR_W];
    endfunction

    spike_priority_enc #(
        .N     (NUM_NEURONS),
        .IDX_W (IDX_W)
    ) u_enc (
        .req (pending),
        .idx (sel_idx),
        .any (sel_any)
    );

    // Range lookup for the selected neuron and end-of-list detection.
    always_comb begin
        scan_ptr      = cp_at(sel_idx);
        scan_end      = cp_at(sel_idx + IDX_W'(1));
        scan_bad      = (scan_end < scan_ptr) || (int'(scan_end) > MAX_CONN);
        scan_empty    = (scan_end == scan_ptr);
        ptr_inc       = ptr + PTR_W'(1);
        dispatch_last = (ptr_inc == end_ptr);
    end

    // State register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (start) state_next = ST_CLEAR;
            ST_CLEAR:     state_next = ST_INTEGRATE;
            ST_INTEGRATE: if (cnt == '0) state_next = ST_SCAN;
            ST_SCAN: begin
                if (!sel_any)                     state_next = start ? ST_CLEAR : ST_IDLE;
                else if (!scan_bad && !scan_empty) state_next = ST_DISPATCH;
            end
            ST_DISPATCH:  if (dlv_ready && dispatch_last) state_next = ST_SCAN;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Registered outputs, configuration capture and per-state datapath.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            clear      <= 1'b0;
            timestep   <= '0;
            busy       <= 1'b0;
            dlv_valid  <= 1'b0;
            dlv_dest   <= '0;
            dlv_source <= '0;
            cfg_err    <= 1'b0;
            naddr_cfg  <= '0;
            cp_cfg     <= '0;
            ds_cfg     <= '0;
            pending    <= '0;
            cnt        <= '0;
            ptr        <= '0;
            end_ptr    <= '0;
        end else begin
            clear <= (state_next == ST_CLEAR);
            busy  <= (state_next != ST_IDLE);
            if (state_next == ST_CLEAR) timestep <= timestep + 16'd1;
            case (state)
                ST_IDLE: begin
                    if (cfg_load) begin
                        naddr_cfg <= neuron_addresses_initialization;
                        cp_cfg    <= connection_pointer_initialization;
                        ds_cfg    <= downstream_connections_initialization;
                        cfg_err   <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    pending <= '0;
                    cnt     <= CNT_W'(TIMESTEP_CYCLES - 1);
                end
                ST_INTEGRATE: begin
                    pending <= pending | spikes;
                    cnt     <= cnt - CNT_W'(1);
                end
                ST_SCAN: begin
                    if (sel_any) begin
                        pending <= pending & ~(NUM_NEURONS'(1) << sel_idx);
                        ptr     <= scan_ptr;
                        end_ptr <= scan_end;
                        if (scan_bad) begin
                            cfg_err <= 1'b1;
                        end else if (!scan_empty) begin
                            dlv_valid  <= 1'b1;
                            dlv_dest   <= ds_at(scan_ptr);
                            dlv_source <= naddr_at(sel_idx);
                        end
                    end
                end
                ST_DISPATCH: begin
                    if (dlv_ready) begin
                        if (dispatch_last) begin
                            dlv_valid <= 1'b0;
                        end else begin
                            ptr      <= ptr_inc;
                            dlv_dest <= ds_at(ptr_inc);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCHED_STALL_COUNT_EN
    // Backpressure cycles within the current timestep, saturating at 0xFFFF.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            stall_cycles <= '0;
        else if (state == ST_CLEAR)
            stall_cycles <= '0;
        else if (dlv_valid && !dlv_ready && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
`else
    // Stall counting is compiled out; there is no stall_cycles port.
`endif

endmodule

// File: tb/tb_spike_dispatch_scheduler.sv
// tb_spike_dispatch_scheduler: directed and randomized checks of the spike
// dispatch scheduler against a list-level reference model.
`timescale 1ns/1ps
module tb_spike_dispatch_scheduler;

    localparam int NN = 10;
    localparam int AW = 12;
    localparam int PW = 5;
    localparam int MC = 30;
    localparam int TC = 4;

    logic                clk = 1'b0;
    logic                rstn;
    logic                start, cfg_load, dlv_ready;
    logic [NN*AW-1:0]    na_bus;
    logic [(NN+1)*PW-1:0] cp_bus;
    logic [MC*AW-1:0]    ds_bus;
    logic [NN-1:0]       spikes;
    logic                clear, dlv_valid, busy, cfg_err;
    logic [15:0]         timestep;
    logic [AW-1:0]       dlv_dest, dlv_source;
`ifdef SCHED_STALL_COUNT_EN
    logic [15:0]         stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          m_naddr [NN];
    int          m_cp    [NN+1];
    int          m_ds    [MC];
    bit          m_err;
    logic [15:0] m_ts;
    int          m_stall;
    logic [23:0] expq [$];

    logic [NN-1:0] sp_cycle [TC];
    int  ready_mode;
    bit  drop_start, cfg_probe;
    int  first_valid_cyc, last_hs_cyc, end_cyc;

    always #5 clk = ~clk;

    spike_dispatch_scheduler dut (
        .CLK                                   (clk),
        .RESETn                                (rstn),
        .start                                 (start),
        .cfg_load                              (cfg_load),
        .neuron_addresses_initialization       (na_bus),
        .connection_pointer_initialization     (cp_bus),
        .downstream_connections_initialization (ds_bus),
        .spikes                                (spikes),
        .clear                                 (clear),
        .timestep                              (timestep),
        .dlv_valid                             (dlv_valid),
        .dlv_ready                             (dlv_ready),
        .dlv_dest                              (dlv_dest),
        .dlv_source                            (dlv_source),
        .busy                                  (busy),
        .cfg_err                               (cfg_err)
`ifdef SCHED_STALL_COUNT_EN
        ,
        .stall_cycles                          (stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_sp(input logic [NN-1:0] a, b, c, d);
        sp_cycle[0] = a; sp_cycle[1] = b; sp_cycle[2] = c; sp_cycle[3] = d;
    endtask

    task automatic set_cfg_a();
        int cpa [NN+1];
        int dsa [10];
        cpa = '{0, 3, 5, 8, 10, 12, 14, 15, 17, 18, 19};
        dsa = '{3, 5, 7, 4, 6, 4, 5, 6, 8, 9};
        for (int i = 0; i < NN; i++) m_naddr[i] = i;
        for (int i = 0; i <= NN; i++) m_cp[i] = cpa[i];
        for (int j = 0; j < MC; j++) m_ds[j] = (j < 10) ? dsa[j] : 100 + j;
    endtask

    task automatic set_cfg_rand();
        m_cp[0] = 0;
        for (int i = 0; i < NN; i++) begin
            m_naddr[i]  = int'($urandom_range(0, 4095));
            m_cp[i + 1] = m_cp[i] + int'($urandom_range(0, 3));
        end
        for (int j = 0; j < MC; j++) m_ds[j] = int'($urandom_range(0, 4095));
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < NN; i++)  na_bus[(NN - 1 - i) * AW +: AW] = AW'(m_naddr[i]);
        for (int i = 0; i <= NN; i++) cp_bus[(NN - i) * PW +: PW]     = PW'(m_cp[i]);
        for (int j = 0; j < MC; j++)  ds_bus[(MC - 1 - j) * AW +: AW] = AW'(m_ds[j]);
        cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        m_err = 1'b0;
        check("cfg_err_after_load", cfg_err, m_err);
    endtask

    task automatic wait_clear();
        int n = 0;
        while (clear !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("clear_seen", clear, 1'b1);
    endtask

    // One full timestep: drives spikes through the integrate window, then
    // collects deliveries and compares them with the model's delivery list.
    task automatic run_timestep();
        logic [NN-1:0] pend;
        logic [23:0]   got, held;
        bit            holding, done, rdy;
        int            p, e, cyc, stall_seen;

        wait_clear();
        m_ts = m_ts + 16'd1;
        check("timestep", timestep, m_ts);
        check("busy_in_run", busy, 1'b1);
        spikes = NN'($urandom);
        if (cfg_probe) begin
            na_bus = '0; cp_bus = '0; ds_bus = '0;
            cfg_load = 1'b1;
        end
        for (int k = 0; k < TC; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                check("clear_one_cycle", clear, 1'b0);
                cfg_load = 1'b0;
            end
            spikes = sp_cycle[k];
            if (drop_start && k == 1) start = 1'b0;
        end
        @(posedge clk); #1;
        spikes = NN'($urandom);

        pend = '0;
        for (int k = 0; k < TC; k++) pend |= sp_cycle[k];
        expq.delete();
        for (int i = 0; i < NN; i++) begin
            if (pend[i]) begin
                p = m_cp[i];
                e = m_cp[i + 1];
                if (e < p || e > MC) m_err = 1'b1;
                else for (int j = p; j < e; j++) expq.push_back({AW'(m_ds[j]), AW'(m_naddr[i])});
            end
        end

        cyc = 0; holding = 0; done = 0; stall_seen = 0; m_stall = 0;
        held = '0;
        first_valid_cyc = -1; last_hs_cyc = -1; end_cyc = -1;
        for (int t = 0; t < 400; t++) begin
            if (!dlv_valid && expq.size() == 0 && (clear || !busy)) begin
                done = 1; end_cyc = cyc;
                break;
            end
            if (dlv_valid) begin
                got = {dlv_dest, dlv_source};
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (holding)                check("dlv_held", got, held);
                else if (expq.size() == 0)  check("dlv_unexpected", dlv_valid, 1'b0);
                else                        check("dlv_pair", got, expq[0]);
                if (ready_mode == 0)      rdy = 1'b1;
                else if (ready_mode == 1) rdy = ($urandom_range(0, 3) != 0);
                else if (stall_seen < 3) begin rdy = 1'b0; stall_seen++; end
                else                      rdy = 1'b1;
                dlv_ready = rdy;
                if (rdy) begin
                    if (expq.size() > 0) void'(expq.pop_front());
                    holding = 0;
                    last_hs_cyc = cyc;
                end else begin
                    holding = 1;
                    held = got;
                    m_stall++;
                end
            end else begin
                if (holding) check("dlv_valid_dropped", dlv_valid, 1'b1);
                holding = 0;
                dlv_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("timestep_done", done, 1'b1);
        check("queue_drained", expq.size(), 0);
        check("cfg_err", cfg_err, m_err);
        check("end_clear", clear, start);
        check("end_busy", busy, start);
`ifdef SCHED_STALL_COUNT_EN
        check("stall_cycles", stall_cycles, m_stall);
`endif
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk); #1;
        check("start_to_clear", clear, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; cfg_load = 1'b0; dlv_ready = 1'b1;
        spikes = '0; na_bus = '0; cp_bus = '0; ds_bus = '0;
        m_ts = '0; m_err = 1'b0; m_stall = 0;
        ready_mode = 0; drop_start = 0; cfg_probe = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clear", clear, 1'b0);
        check("rst_timestep", timestep, 16'd0);
        check("rst_dlv_valid", dlv_valid, 1'b0);
        check("rst_dlv_dest", dlv_dest, '0);
        check("rst_dlv_source", dlv_source, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Single spike on neuron 0: three back-to-back deliveries.
        set_cfg_a();
        apply_cfg();
        kick();
        set_sp(10'b1, 0, 0, 0);
        run_timestep();
        check("t1_first_valid", first_valid_cyc, 1);
        check("t1_last_hs", last_hs_cyc, 3);
        check("t1_next_clear", end_cyc, 5);

        // Neurons 0 and 2 on different cycles, neuron 0 repeated.
        set_sp(10'b1, 10'b1, 10'b100, 0);
        run_timestep();
        check("t2_first_valid", first_valid_cyc, 1);
        check("t2_last_hs", last_hs_cyc, 7);
        check("t2_next_clear", end_cyc, 9);

        // Backpressure on the first delivery; cfg_load outside IDLE ignored.
        ready_mode = 2; cfg_probe = 1;
        set_sp(10'b1, 0, 0, 0);
        run_timestep();
        ready_mode = 0; cfg_probe = 0;

        // Stop request mid-integrate: finish dispatch, then go idle.
        ready_mode = 1; drop_start = 1;
        set_sp(NN'($urandom), NN'($urandom), NN'($urandom), NN'($urandom));
        run_timestep();
        drop_start = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("idle_no_clear", clear, 1'b0);
            check("idle_not_busy", busy, 1'b0);
        end

        // Random configuration and sparse random spikes with random ready.
        set_cfg_rand();
        apply_cfg();
        kick();
        for (int n = 0; n < 6; n++) begin
            drop_start = (n == 5);
            set_sp(NN'($urandom & $urandom & $urandom), NN'($urandom & $urandom & $urandom),
                   NN'($urandom & $urandom & $urandom), NN'($urandom & $urandom & $urandom));
            run_timestep();
        end

        // Empty range for neuron 1: skipped, no error.
        ready_mode = 0;
        set_cfg_a();
        m_cp[2] = 3;
        apply_cfg();
        kick();
        drop_start = 1;
        set_sp(10'b10, 10'b100, 0, 0);
        run_timestep();

        // Inverted range for neuron 1: skipped with sticky cfg_err.
        set_cfg_a();
        m_cp[2] = 2;
        apply_cfg();
        kick();
        set_sp(10'b10, 10'b100, 0, 0);
        run_timestep();
        check("cfg_err_sticky", cfg_err, 1'b1);

        // Reload clears cfg_err; then reset during the second dispatch cycle.
        set_cfg_a();
        apply_cfg();
        drop_start = 0;
        dlv_ready = 1'b1;
        start = 1'b1;
        wait_clear();
        m_ts = m_ts + 16'd1;
        for (int k = 0; k < TC; k++) begin
            @(posedge clk); #1;
            spikes = (k == 0) ? NN'(1) : '0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rmid_first_valid", dlv_valid, 1'b1);
        @(posedge clk); #1;
        check("rmid_second_dest", dlv_dest, 12'd5);
        rstn = 1'b0;
        #1;
        check("rmid_dlv_valid", dlv_valid, 1'b0);
        check("rmid_timestep", timestep, 16'd0);
        check("rmid_busy", busy, 1'b0);
        check("rmid_clear", clear, 1'b0);
        @(negedge clk); rstn = 1'b1;
        for (int i = 0; i < NN; i++)  m_naddr[i] = 0;
        for (int i = 0; i <= NN; i++) m_cp[i] = 0;
        for (int j = 0; j < MC; j++)  m_ds[j] = 0;
        m_ts = '0; m_err = 1'b0;

        // No reload after reset: every range is empty, nothing delivered.
        drop_start = 1;
        set_sp('1, '1, '1, '1);
        run_timestep();
        drop_start = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
